// File: rtl/bcx_pkg.sv
// Shared types and constants for the compact-target block.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
//
// compact_t   : numeric compact target, {exponent, mantissa}.
// state_t     : controller states of target_compactor.
// to_le_bits  : re-packs a compact_t into the byte-swapped layout that
//               hash_validator consumes.
package bcx_pkg;

  localparam int TARGET_BYTES  = 32;
  localparam int MANT_BYTES    = 3;
  localparam int MANT_SIGN_BIT = 23;

  typedef struct packed {
    logic [7:0]  exponent;
    logic [23:0] mantissa;
  } compact_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_PACK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Exponent stays in the top byte; the three mantissa bytes are
  // reversed so the most significant mantissa byte lands in [7:0].
  function automatic logic [31:0] to_le_bits(input compact_t c);
    return {c.exponent, c.mantissa[7:0], c.mantissa[15:8], c.mantissa[23:16]};
  endfunction

endpackage

// File: rtl/target_compactor_if.sv
// Handshake bundle between a target producer/result consumer and target_compactor.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the input target and the output result.
//
// in_valid/in_ready/target_i      : 256-bit target input handshake.
// out_valid/out_ready             : compact result handshake.
// bits_num_o                      : numeric compact value {exp, mantissa}.
// bits_o                          : same value, mantissa bytes reversed.
// master modport = environment side, slave modport = the compactor.
interface target_compactor_if;

  logic         in_valid;
  logic         in_ready;
  logic [255:0] target_i;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  bits_num_o;
  logic [31:0]  bits_o;

  modport master (
    output in_valid,
    output target_i,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  bits_num_o,
    input  bits_o
  );

  modport slave (
    input  in_valid,
    input  target_i,
    input  out_ready,
    output in_ready,
    output out_valid,
    output bits_num_o,
    output bits_o
  );

endinterface

// File: rtl/compact_normalize.sv
// Extracts the 24-bit mantissa of a target given its significant byte count and normalises it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller samples the outputs when it needs them.
//
// target_i   : 256-bit numeric target (byte k = bits [8k+7:8k]).
// size_i     : number of significant bytes, 0..32.
// exponent_o : size_i, plus one when the mantissa had to be shifted down.
// mantissa_o : top three significant bytes, kept positive (bit 23 clear).
module compact_normalize
  import bcx_pkg::*;
(
  input  logic [8*TARGET_BYTES-1:0] target_i,
  input  logic [5:0]                size_i,
  output logic [7:0]                exponent_o,
  output logic [23:0]               mantissa_o
);

  logic [23:0] m_raw;
  logic [4:0]  rshift_bytes;

  // Raw mantissa: short targets are left-aligned into 24 bits, long
  // targets contribute their top three significant bytes.
  always_comb begin
    m_raw        = '0;
    rshift_bytes = 5'(size_i - 6'(MANT_BYTES));
    if (size_i <= 6'(MANT_BYTES)) begin
      case (size_i[1:0])
        2'd1:    m_raw = {target_i[7:0], 16'h0000};
        2'd2:    m_raw = {target_i[15:0], 8'h00};
        2'd3:    m_raw = target_i[23:0];
        default: m_raw = '0;
      endcase
    end else begin
      // size 4..32 -> byte offset 1..29, so the 24-bit window never
      // runs past bit 255.
      m_raw = target_i[{rshift_bytes, 3'b000} +: 24];
    end
  end

  // Bit 23 acts as a sign bit downstream, so a set top bit forces one
  // more exponent step and a byte shift of the mantissa.
  always_comb begin
    exponent_o = {2'b00, size_i};
    mantissa_o = m_raw;
    if (m_raw[MANT_SIGN_BIT] && (size_i != 6'd0)) begin
      mantissa_o = m_raw >> 8;
      exponent_o = {2'b00, size_i} + 8'd1;
    end
  end

endmodule

// File: rtl/target_compactor.sv
// Converts a 256-bit target into its 32-bit compact form, in numeric and byte-swapped layouts.
// Latency: 34-size edges from accept to out_valid (33 for a zero target, 2 minimum).
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// clk, rst_n : clock and asynchronous active-low reset.
// bus        : slave side of target_compactor_if (target in, compact out).
module target_compactor
  import bcx_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  target_compactor_if.slave   bus
);

  localparam logic [4:0] IDX_TOP = 5'(TARGET_BYTES - 1);

  state_t                    state_q, state_d;
  logic [8*TARGET_BYTES-1:0] target_q, target_d;
  logic [4:0]                idx_q, idx_d;
  logic [5:0]                size_q, size_d;
  compact_t                  res_q, res_d;

  logic [7:0]  scan_byte;
  logic        scan_stop;
  logic [7:0]  norm_exp;
  logic [23:0] norm_mant;

  // Byte under inspection during SCAN, walking down from the MS byte.
  assign scan_byte = target_q[{idx_q, 3'b000} +: 8];
  // Stop at the first nonzero byte, or after byte 0 for an all-zero target.
  assign scan_stop = (scan_byte != 8'h00) || (idx_q == 5'd0);

  compact_normalize u_norm (
    .target_i   (target_q),
    .size_i     (size_q),
    .exponent_o (norm_exp),
    .mantissa_o (norm_mant)
  );

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.in_valid)  state_d = ST_SCAN;
      ST_SCAN: if (scan_stop)     state_d = ST_PACK;
      ST_PACK:                    state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
  end

  // Result registers are only written in PACK, so both encodings hold
  // their last value in every other state.
  assign bus.bits_num_o = res_q;
  assign bus.bits_o     = to_le_bits(res_q);

  // ---------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------
  always_comb begin
    target_d = target_q;
    idx_d    = idx_q;
    size_d   = size_q;
    res_d    = res_q;
    case (state_q)
      ST_IDLE: begin
        // Target is captured once here; target_i is not looked at again
        // until the next acceptance.
        if (bus.in_valid) begin
          target_d = bus.target_i;
          idx_d    = IDX_TOP;
        end
      end
      ST_SCAN: begin
        if (scan_byte != 8'h00) begin
          size_d = {1'b0, idx_q} + 6'd1;
        end else if (idx_q == 5'd0) begin
          size_d = 6'd0;
        end else begin
          idx_d = idx_q - 5'd1;
        end
      end
      ST_PACK: begin
        res_d.exponent = norm_exp;
        res_d.mantissa = norm_mant;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      idx_q    <= IDX_TOP;
      size_q   <= '0;
      res_q    <= '0;
    end else begin
      target_q <= target_d;
      idx_q    <= idx_d;
      size_q   <= size_d;
      res_q    <= res_d;
    end
  end

endmodule

// File: tb/tb_target_compactor.sv
module tb_target_compactor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  target_compactor_if bus ();

  target_compactor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_num = '0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_size(input logic [255:0] t);
    int s = 0;
    for (int k = 0; k < 32; k++)
      if (t[8*k +: 8] != 8'h00) s = k + 1;
    return s;
  endfunction

  function automatic logic [31:0] model(input logic [255:0] t);
    int          s;
    int          e;
    logic [255:0] v;
    logic [23:0] m;
    s = model_size(t);
    if (s <= 3) v = t << (8 * (3 - s));
    else        v = t >> (8 * (s - 3));
    m = v[23:0];
    e = s;
    if (m[23] && s > 0) begin
      m = m >> 8;
      e = e + 1;
    end
    return {e[7:0], m};
  endfunction

  function automatic int model_lat(input logic [255:0] t);
    int s = model_size(t);
    return (s == 0) ? 33 : 34 - s;
  endfunction

  function automatic logic [31:0] swap_enc(input logic [31:0] n);
    return {n[31:24], n[7:0], n[15:8], n[23:16]};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_valid_excl", {63'd0, bus.in_ready & bus.out_valid}, 64'd0);
      if (bus.out_valid && chk_en) begin
        check("model_bits_num", {32'd0, bus.bits_num_o}, {32'd0, exp_num});
        check("model_bits",     {32'd0, bus.bits_o},     {32'd0, swap_enc(exp_num)});
      end
    end
  end

  // ---------------- one full transaction ----------------
  task automatic run_txn(input logic [255:0] t, input int stall, input bit noisy,
                         output logic [31:0] num, output logic [31:0] bo, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 64'd0, 64'd1);
    bus.in_valid  = 1'b1;
    bus.target_i  = t;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    exp_num = model(t);
    chk_en  = 1'b1;
    bus.in_valid = 1'b0;
    bus.target_i = rand256();
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (noisy) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.target_i = rand256();
      end
    end
    check("latency", 64'(lat), 64'(model_lat(t)));
    num = bus.bits_num_o;
    bo  = bus.bits_o;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("stall_in_ready",  {63'd0, bus.in_ready},  64'd0);
      check("stall_hold_num",  {32'd0, bus.bits_num_o}, {32'd0, num});
      check("stall_hold_bits", {32'd0, bus.bits_o},     {32'd0, bo});
      if (noisy) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.target_i = rand256();
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk_en = 1'b0;
    check("release_to_idle", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
  endtask

  // ---------------- directed + random stimulus ----------------
  typedef struct {
    logic [255:0] t;
    logic [31:0]  num;
    logic [31:0]  bo;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] num;
    logic [31:0] bo;
    int          lat;
    logic [255:0] t;
    int          sz;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.target_i  = '0;

    vecs[0] = '{256'hFFFF << 208,  32'h1D00FFFF, 32'h1DFFFF00, 6};
    vecs[1] = '{256'h12,           32'h01120000, 32'h01000012, 33};
    vecs[2] = '{256'h80,           32'h02008000, 32'h02008000, 33};
    vecs[3] = '{~256'h0,           32'h2100FFFF, 32'h21FFFF00, 2};
    vecs[4] = '{256'h0,            32'h00000000, 32'h00000000, 33};
    vecs[5] = '{256'h123456,       32'h03123456, 32'h03563412, 31};
    vecs[6] = '{256'h800000,       32'h04008000, 32'h04008000, 31};
    vecs[7] = '{256'h12345678,     32'h04123456, 32'h04563412, 30};

    // Reset state
    #12;
    check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_bits_num",  {32'd0, bus.bits_num_o}, 64'd0);
    check("rst_bits",      {32'd0, bus.bits_o},     64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed vectors pin both the model and the DUT
    foreach (vecs[i]) begin
      check("model_pin", {32'd0, model(vecs[i].t)}, {32'd0, vecs[i].num});
      run_txn(vecs[i].t, i % 3, 1'b0, num, bo, lat);
      check("vec_bits_num", {32'd0, num}, {32'd0, vecs[i].num});
      check("vec_bits",     {32'd0, bo},  {32'd0, vecs[i].bo});
      check("vec_latency",  64'(lat),     64'(vecs[i].lat));
    end

    // Backpressure: 5 stalled cycles with noisy input side
    run_txn(256'hFFFF << 208, 5, 1'b1, num, bo, lat);
    check("bp_bits_num", {32'd0, num}, 64'h1D00FFFF);

    // Asynchronous reset in the middle of SCAN
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.target_i = 256'h12;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("arst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    check("arst_bits_num",  {32'd0, bus.bits_num_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(256'h12, 1, 1'b0, num, bo, lat);
    check("post_rst_bits_num", {32'd0, num}, 64'h01120000);
    check("post_rst_latency",  64'(lat),     64'd33);

    // Random targets with random stalls on both sides
    for (int n = 0; n < 1000; n++) begin
      sz = $urandom_range(0, 32);
      t  = '0;
      for (int k = 0; k < sz; k++) t[8*k +: 8] = 8'($urandom);
      if (sz > 0 && t[8*(sz-1) +: 8] == 8'h00) t[8*(sz-1) +: 8] = 8'($urandom_range(1, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(t, $urandom_range(0, 3), 1'b1, num, bo, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/target_compactor.md
TARGET_COMPACTOR -- requirements
Module: target_compactor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  target_i is valid this cycle.
REQ-005 in_ready  output  1  block can accept a target this cycle.
REQ-006 target_i  input  256  target, numeric: bit 255 = MSB; byte k = bits [8k+7:8k].
REQ-007 out_valid  output  1  compact result is valid.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 bits_num_o  output  32  compact target, numeric: [31:24] exponent, [23:0] mantissa.
REQ-010 bits_o  output  32  same value in the format hash_validator consumes:
- [31:24] exponent.
- [7:0] mantissa MS byte, [15:8] middle byte, [23:16] LS byte.

Function
REQ-011 Transfers SHALL complete on a rising edge where valid and ready are both high, on either side.
REQ-012 States SHALL be IDLE, SCAN, PACK and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 IDLE with in_valid=1: latch target_i, set byte index idx=31, go to SCAN.
REQ-015 SCAN SHALL examine one byte per cycle, byte idx of the latched target:
- nonzero: size=idx+1, go to PACK.
- zero and idx=0: size=0, go to PACK.
- otherwise: idx decrements by 1.
REQ-016 PACK SHALL compute the mantissa m in one cycle:
- size<=3: m = target[23:0] << 8*(3-size), truncated to 24 bits.
- size>3: m = bits [23:0] of (target >> 8*(size-3)).
REQ-017 PACK normalisation: if m[23]=1 and size>0, then m = m>>8 and size = size+1.
- Exponent range is 0..33; 8 bits, no overflow.
REQ-018 PACK SHALL register exponent=size and mantissa=m into both output encodings, then go to DONE.
REQ-019 A zero target SHALL produce 0x00000000 on both outputs.
REQ-020 out_valid SHALL rise (34 - size) rising edges after the accepting edge for size>=1, and 33 edges after it for size 0.
- Minimum is 2 edges.
REQ-021 DONE SHALL hold outputs and out_valid stable until out_ready=1, then go to IDLE.
- The next acceptance occurs no earlier than the following edge.
REQ-022 in_valid SHALL be ignored outside IDLE.
- target_i changes during SCAN or PACK SHALL NOT affect the result.
REQ-023 bits_num_o and bits_o SHALL always carry the same value in their respective encodings.
REQ-024 Outputs SHALL hold their last value when not in DONE; consumers qualify them with out_valid.

Reset
REQ-025 While rst_n=0 the block SHALL be in IDLE with:
- in_ready=1, out_valid=0.
- bits_num_o=0, bits_o=0, idx=31, latched target=0.
REQ-026 Reset asserted in any state, including mid-SCAN or DONE, SHALL immediately abandon the operation with no result produced.
REQ-027 After reset deasserts, the first rising edge SHALL be able to accept a new target.

Structure
REQ-028 Shared package bcx_pkg SHALL hold:
- typedef compact_t, a packed struct {exponent 8, mantissa 24}.
- Constants TARGET_BYTES=32, MANT_BYTES=3, MANT_SIGN_BIT=23.
- The state enum.
REQ-029 The mantissa extraction and normalisation of REQ-016 and REQ-017 SHALL be one combinational sub-module, compact_normalize.
- Inputs: target and size. Outputs: exponent and mantissa.
REQ-030 FSM, idx counter, target register and output registers SHALL live in target_compactor.

Verification
REQ-031 target=0xFFFF<<208 (difficulty 1):
- out_valid after 6 edges.
- bits_num_o=0x1D00FFFF, bits_o=0x1DFFFF00.
REQ-032 target=0x12 -> bits_num_o=0x01120000 after 33 edges; target=0x80 -> bits_num_o=0x02008000 (normalisation at small size).
REQ-033 target=all-ones -> bits_num_o=0x2100FFFF after 2 edges; target=0 -> 0x00000000 after 33 edges.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and a changing in_valid/target_i is ignored.
- Releasing out_ready -> IDLE on the next edge.
REQ-035 Assert rst_n=0 asynchronously mid-SCAN -> out_valid=0 and in_ready=1 immediately.
- A subsequent target=0x12 yields 0x01120000 with no stale result.
REQ-036 Random targets, 1000 transactions with random handshake stalls -> results match a reference model of REQ-016 to REQ-019, and the latency matches REQ-020.
